video_capture_sched: RTL and testbench
======================================

# video_capture_sched

Frame-level capture scheduler for the vision pipeline's video-to-DRAM path. It watches the AXI4-Stream video framing (tuser/tlast/tvalid) on vid_clk and opens the pixel-write gate for exactly one whole frame per request, from start-of-frame to the last line. It selects the DRAM buffer for each frame from a ring of NUM_BUF buffers, never selecting the buffer currently locked by the display reader. It reports completion, the written buffer index, and framing errors.

## Interface
Parameters:
- WIDTH, 1600, active pixels per line
- HEIGHT, 1200, active lines per frame
- NUM_BUF, 3, frame buffers in the ring (2..4)
- BUF_BASE, 32'h0000_0000, byte address of buffer 0
- BUF_STRIDE, 32'h0080_0000, byte distance between buffers

Ports:
- Reset rst, synchronous, active-high; clock vid_clk.
- vid_clk  in  1  video clock; all logic on rising edge
- rst  in  1  synchronous active-high reset
- s_axis_tvalid  in  1  pixel beat valid (monitor only; tready is always 1 downstream)
- s_axis_tuser  in  1  start of frame, on first beat
- s_axis_tlast  in  1  end of line, on last beat of each line
- cap_req  in  1  single-shot capture request (pulse)
- cap_cont  in  1  continuous capture (level)
- disp_lock  in  1  display reader holds buffer disp_buf
- disp_buf  in  2  index of the locked buffer
- cap_en  out  1  write gate to the pixel writer (combinational, see Timing)
- frame_base  out  32  byte base of the buffer being written
- busy  out  1  state != IDLE
- frame_done  out  1  one-cycle pulse: frame fully written
- done_buf  out  2  buffer index of the last completed frame
- err_line  out  1  one-cycle pulse: line length != WIDTH
- err_frame  out  1  one-cycle pulse: SOF before HEIGHT lines completed
- frame_cnt  out  16  completed frames, wraps 0xFFFF->0

## Operation
- Beat = cycle with s_axis_tvalid=1; non-valid cycles are ignored by every counter and state transition.
- States: IDLE, ARM, CAPTURE, DONE.
- IDLE: if cap_req or cap_cont, select the next buffer, load frame_base, go to ARM.
- Buffer select: cand = (cur_buf+1) mod NUM_BUF. If disp_lock && cand==disp_buf, then cand = (cand+1) mod NUM_BUF. cur_buf <= cand. frame_base = BUF_BASE + cand*BUF_STRIDE, 32-bit, wrap ignored.
- ARM: wait for a beat with tuser=1; that beat is captured. Go to CAPTURE with x_cnt=1, y_cnt=0. If that beat also has tlast, line handling applies in the same cycle.
- CAPTURE: each beat increments x_cnt (12 bit). On a tlast beat, if x_cnt+1 != WIDTH, pulse err_line. Then x_cnt=0 and y_cnt+1. When the tlast beat completes line HEIGHT-1, go to DONE.
- tuser beat in CAPTURE (premature SOF): pulse err_frame. Restart the frame in the same buffer at that beat (x_cnt=1, y_cnt=0). cap_en stays high.
- tuser and tlast on the same beat in CAPTURE: err_frame takes precedence; the beat counts as line 0 end, y_cnt=1.
- DONE (1 cycle): pulse frame_done, done_buf<=cur_buf, frame_cnt+1. Then, if cap_cont, select the next buffer and go to ARM; else go to IDLE.
- cap_req while busy is ignored (not queued). Dropping cap_cont mid-frame finishes the current frame, then goes to IDLE.
- disp_lock is sampled only at buffer selection; a change mid-frame has no effect on frame_base.
- Reset values: state IDLE, cur_buf NUM_BUF-1, frame_base BUF_BASE, cap_en 0, busy 0, frame_done 0, done_buf 0, err_line 0, err_frame 0, frame_cnt 0, x_cnt/y_cnt 0.
- rst mid-frame aborts with no frame_done. The first selection after reset is buffer 0.

## Timing
- cap_req/cap_cont sampled at the IDLE edge; ARM and a valid frame_base appear in the next cycle.
- cap_en = (ARM && tvalid && tuser) || CAPTURE. It is combinational so the SOF beat is gated in the same cycle.
- The DONE cycle immediately follows the final tlast beat; cap_en=0 in DONE.
- A SOF arriving during DONE is not captured; the next capture waits for the following SOF.
- frame_base changes only on an IDLE->ARM or DONE->ARM transition.
- err_* and frame_done are registered, asserted the cycle after the causing beat, and high for exactly 1 cycle.

## Test plan
Bench parameters: WIDTH=8, HEIGHT=4, NUM_BUF=3, BUF_BASE=0x1000, BUF_STRIDE=0x100.
- Single shot: cap_req pulse, then a clean 8x4 frame → frame_base=0x1000, cap_en high on exactly 32 beats, one frame_done, done_buf=0, frame_cnt=1, busy back to 0.
- Continuous: cap_cont=1 for 4 frames → frame_base sequence 0x1000, 0x1100, 0x1200, 0x1000; done_buf 0,1,2,0.
- Display lock: after buffer 0 completes, set disp_lock=1, disp_buf=1 → next frame uses 0x1200. With NUM_BUF=2, cur=0, lock=1 → reuses 0x1000.
- Errors: line 2 has 7 beats → one err_line, frame still completes. SOF after 2 lines → err_frame, 32 more beats, then frame_done.
- Gaps and late request: tvalid toggling 50% → same 32 gated beats. cap_req mid-frame → capture starts at the next SOF. Second cap_req while busy → ignored.
- Reset: rst during CAPTURE → cap_en=0 and busy=0 the next cycle, no frame_done; the next cap_req uses 0x1000.

Source files
------------

// File: rtl/video_capture_sched_if.sv
// Bundle of the video framing monitor inputs, capture control and status
// outputs for video_capture_sched. The DUT uses the slave view.
interface video_capture_sched_if;
  logic        s_axis_tvalid;
  logic        s_axis_tuser;
  logic        s_axis_tlast;
  logic        cap_req;
  logic        cap_cont;
  logic        disp_lock;
  logic [1:0]  disp_buf;
  logic        cap_en;
  logic [31:0] frame_base;
  logic        busy;
  logic        frame_done;
  logic [1:0]  done_buf;
  logic        err_line;
  logic        err_frame;
  logic [15:0] frame_cnt;
  logic [1:0]  dbg_state;

  modport master (
    output s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    output cap_req, cap_cont, disp_lock, disp_buf,
    input  cap_en, frame_base, busy, frame_done, done_buf,
    input  err_line, err_frame, frame_cnt, dbg_state
  );

  modport slave (
    input  s_axis_tvalid, s_axis_tuser, s_axis_tlast,
    input  cap_req, cap_cont, disp_lock, disp_buf,
    output cap_en, frame_base, busy, frame_done, done_buf,
    output err_line, err_frame, frame_cnt, dbg_state
  );
endinterface

// File: rtl/video_capture_sched.sv
// Frame-level capture scheduler: gates exactly one whole frame per request into
// a ring of DRAM buffers, skipping the buffer locked by the display reader.
module video_capture_sched #(
  parameter int          WIDTH      = 1600,
  parameter int          HEIGHT     = 1200,
  parameter int          NUM_BUF    = 3,
  parameter logic [31:0] BUF_BASE   = 32'h0000_0000,
  parameter logic [31:0] BUF_STRIDE = 32'h0080_0000
) (
  input logic                   vid_clk,
  input logic                   rst,
  video_capture_sched_if.slave  vif
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam logic [1:0]  LAST_BUF  = 2'(NUM_BUF - 1);
  localparam logic [11:0] WIDTH_C   = 12'(WIDTH);
  localparam logic [11:0] LAST_LINE = 12'(HEIGHT - 1);

  function automatic logic [1:0] next_buf(input logic [1:0] b);
    return (b == LAST_BUF) ? 2'd0 : b + 2'd1;
  endfunction

  state_t      r_state;
  state_t      w_state_nxt;
  logic [1:0]  r_cur_buf;
  logic [31:0] r_frame_base;
  logic [11:0] r_x_cnt;
  logic [11:0] r_y_cnt;
  logic        r_frame_done;
  logic [1:0]  r_done_buf;
  logic        r_err_line;
  logic        r_err_frame;
  logic [15:0] r_frame_cnt;

  logic        w_select;
  logic        w_beat;
  logic        w_sof;
  logic        w_cap_beat;
  logic        w_eol;
  logic        w_last_line;
  logic        w_err_frame_set;
  logic        w_err_line_set;
  logic [11:0] w_line_x;
  logic [11:0] w_line_y;
  logic [11:0] w_x_inc;
  logic [1:0]  w_cand_a;
  logic [1:0]  w_cand;

  // A SOF beat (in ARM, or premature in CAPTURE) restarts the line/frame
  // position, so line handling on that same beat sees x=0, y=0.
  assign w_beat          = vif.s_axis_tvalid;
  assign w_sof           = w_beat && vif.s_axis_tuser &&
                           ((r_state == ST_ARM) || (r_state == ST_CAPTURE));
  assign w_cap_beat      = w_sof || (w_beat && (r_state == ST_CAPTURE));
  assign w_line_x        = w_sof ? 12'd0 : r_x_cnt;
  assign w_line_y        = w_sof ? 12'd0 : r_y_cnt;
  assign w_x_inc         = w_line_x + 12'd1;
  assign w_eol           = w_cap_beat && vif.s_axis_tlast;
  assign w_last_line     = w_eol && (w_line_y == LAST_LINE);
  assign w_err_frame_set = w_sof && (r_state == ST_CAPTURE);
  assign w_err_line_set  = w_eol && (w_x_inc != WIDTH_C) && !w_err_frame_set;

  // Never hand the writer the buffer the display is scanning out.
  assign w_cand_a = next_buf(r_cur_buf);
  assign w_cand   = (vif.disp_lock && (w_cand_a == vif.disp_buf)) ?
                    next_buf(w_cand_a) : w_cand_a;

  always_ff @(posedge vid_clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_select    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (vif.cap_req || vif.cap_cont) begin
          w_select    = 1'b1;
          w_state_nxt = ST_ARM;
        end
      end
      ST_ARM, ST_CAPTURE: begin
        if (w_last_line)  w_state_nxt = ST_DONE;
        else if (w_sof)   w_state_nxt = ST_CAPTURE;
      end
      ST_DONE: begin
        if (vif.cap_cont) begin
          w_select    = 1'b1;
          w_state_nxt = ST_ARM;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge vid_clk) begin
    if (rst) begin
      r_cur_buf    <= LAST_BUF;
      r_frame_base <= BUF_BASE;
      r_x_cnt      <= 12'd0;
      r_y_cnt      <= 12'd0;
      r_frame_done <= 1'b0;
      r_done_buf   <= 2'd0;
      r_err_line   <= 1'b0;
      r_err_frame  <= 1'b0;
      r_frame_cnt  <= 16'd0;
    end else begin
      if (w_select) begin
        r_cur_buf    <= w_cand;
        r_frame_base <= BUF_BASE + 32'(w_cand) * BUF_STRIDE;
      end
      if (w_cap_beat) begin
        if (w_eol) begin
          r_x_cnt <= 12'd0;
          r_y_cnt <= w_line_y + 12'd1;
        end else begin
          r_x_cnt <= w_x_inc;
          r_y_cnt <= w_line_y;
        end
      end
      r_frame_done <= w_last_line;
      r_err_line   <= w_err_line_set;
      r_err_frame  <= w_err_frame_set;
      if (w_last_line) begin
        r_done_buf  <= r_cur_buf;
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

  // Combinational so the SOF beat itself is written.
  assign vif.cap_en     = ((r_state == ST_ARM) && vif.s_axis_tvalid && vif.s_axis_tuser) ||
                          (r_state == ST_CAPTURE);
  assign vif.frame_base = r_frame_base;
  assign vif.busy       = (r_state != ST_IDLE);
  assign vif.frame_done = r_frame_done;
  assign vif.done_buf   = r_done_buf;
  assign vif.err_line   = r_err_line;
  assign vif.err_frame  = r_err_frame;
  assign vif.frame_cnt  = r_frame_cnt;
  assign vif.dbg_state  = r_state;

endmodule

// File: tb/tb_video_capture_sched.sv
// Directed bench for video_capture_sched: stimulus pushes one expected record
// per frame; a negedge monitor pops and compares on every frame_done.
module tb_video_capture_sched;
  localparam int          WIDTH  = 8;
  localparam int          HEIGHT = 4;
  localparam logic [31:0] BASE   = 32'h1000;
  localparam logic [31:0] STRIDE = 32'h0100;
  localparam int          EW     = 66;

  logic vid_clk = 1'b0;
  logic rst     = 1'b1;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Record: base[65:34] buf[33:32] cnt[31:16] beats[15:8] err_line[7:4] err_frame[3:0]
  logic [EW-1:0] exp_q[$];

  video_capture_sched_if vif1 ();
  video_capture_sched_if vif2 ();

  video_capture_sched #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_BUF(3), .BUF_BASE(BASE), .BUF_STRIDE(STRIDE)
  ) dut (
    .vid_clk (vid_clk),
    .rst     (rst),
    .vif     (vif1.slave)
  );

  // Two-buffer ring sees the same stimulus; only its buffer choice is checked.
  video_capture_sched #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .NUM_BUF(2), .BUF_BASE(BASE), .BUF_STRIDE(STRIDE)
  ) dut2 (
    .vid_clk (vid_clk),
    .rst     (rst),
    .vif     (vif2.slave)
  );

  assign vif2.s_axis_tvalid = vif1.s_axis_tvalid;
  assign vif2.s_axis_tuser  = vif1.s_axis_tuser;
  assign vif2.s_axis_tlast  = vif1.s_axis_tlast;
  assign vif2.cap_req       = vif1.cap_req;
  assign vif2.cap_cont      = vif1.cap_cont;
  assign vif2.disp_lock     = vif1.disp_lock;
  assign vif2.disp_buf      = vif1.disp_buf;

  // ---------------- clock / reset ----------------
  always #5 vid_clk = ~vid_clk;

  task automatic step();
    @(posedge vid_clk);
    #1;
  endtask

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [EW-1:0] rec(input logic [31:0] base, input logic [1:0] b,
                                        input logic [15:0] cnt, input logic [7:0] beats,
                                        input logic [3:0] el, input logic [3:0] ef);
    return {base, b, cnt, beats, el, ef};
  endfunction

  // ---------------- drivers ----------------
  task automatic idle(input int n);
    vif1.s_axis_tvalid = 1'b0;
    vif1.s_axis_tuser  = 1'b0;
    vif1.s_axis_tlast  = 1'b0;
    vif1.cap_req       = 1'b0;
    repeat (n) step();
  endtask

  task automatic pulse_req();
    vif1.cap_req = 1'b1;
    step();
    vif1.cap_req = 1'b0;
  endtask

  // Sends n_lines lines starting with SOF; line short_line is one beat short,
  // gaps inserts a junk non-valid cycle before every beat, and cap_req is
  // raised on valid beat number req_beat.
  task automatic send_lines(input int n_lines, input int short_line, input bit gaps,
                            input int req_beat);
    int b;
    int len;
    b = 0;
    for (int y = 0; y < n_lines; y++) begin
      len = (y == short_line) ? WIDTH - 1 : WIDTH;
      for (int x = 0; x < len; x++) begin
        if (gaps) begin
          vif1.s_axis_tvalid = 1'b0;
          vif1.s_axis_tuser  = 1'($urandom_range(0, 1));
          vif1.s_axis_tlast  = 1'($urandom_range(0, 1));
          vif1.cap_req       = 1'b0;
          step();
        end
        vif1.s_axis_tvalid = 1'b1;
        vif1.s_axis_tuser  = (y == 0) && (x == 0);
        vif1.s_axis_tlast  = (x == len - 1);
        vif1.cap_req       = (b == req_beat);
        step();
        b++;
      end
    end
    idle(0);
  endtask

  // ---------------- monitor / scoreboard ----------------
  int            mon_beats = 0;
  int            mon_el    = 0;
  int            mon_ef    = 0;
  logic [EW-1:0] mon_e;

  always @(negedge vid_clk) begin
    if (rst) begin
      mon_beats = 0;
      mon_el    = 0;
      mon_ef    = 0;
    end else begin
      if (vif1.cap_en && vif1.s_axis_tvalid) mon_beats++;
      if (vif1.err_line)  mon_el++;
      if (vif1.err_frame) mon_ef++;
      if (vif1.frame_done) begin
        if (exp_q.size() == 0) begin
          check("unexpected_frame_done", 32'd1, 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          check("frame_base", vif1.frame_base, mon_e[65:34]);
          check("done_buf", 32'(vif1.done_buf), 32'(mon_e[33:32]));
          check("frame_cnt", 32'(vif1.frame_cnt), 32'(mon_e[31:16]));
          check("gated_beats", 32'(mon_beats), 32'(mon_e[15:8]));
          check("err_line_pulses", 32'(mon_el), 32'(mon_e[7:4]));
          check("err_frame_pulses", 32'(mon_ef), 32'(mon_e[3:0]));
        end
        mon_beats = 0;
        mon_el    = 0;
        mon_ef    = 0;
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    vif1.s_axis_tvalid = 1'b0;
    vif1.s_axis_tuser  = 1'b0;
    vif1.s_axis_tlast  = 1'b0;
    vif1.cap_req       = 1'b0;
    vif1.cap_cont      = 1'b0;
    vif1.disp_lock     = 1'b0;
    vif1.disp_buf      = 2'd0;
    rst = 1'b1;
    repeat (3) step();
    rst = 1'b0;

    // reset state
    check("rst_cap_en", 32'(vif1.cap_en), 32'd0);
    check("rst_busy", 32'(vif1.busy), 32'd0);
    check("rst_frame_done", 32'(vif1.frame_done), 32'd0);
    check("rst_frame_base", vif1.frame_base, 32'h1000);
    check("rst_frame_cnt", 32'(vif1.frame_cnt), 32'd0);
    check("rst_done_buf", 32'(vif1.done_buf), 32'd0);
    check("rst_err_line", 32'(vif1.err_line), 32'd0);
    check("rst_err_frame", 32'(vif1.err_frame), 32'd0);
    check("rst_state", 32'(vif1.dbg_state), 32'd0);

    // single shot
    exp_q.push_back(rec(32'h1000, 2'd0, 16'd1, 8'd32, 4'd0, 4'd0));
    pulse_req();
    check("ss_frame_base", vif1.frame_base, 32'h1000);
    check("ss_busy", 32'(vif1.busy), 32'd1);
    idle(1);
    send_lines(HEIGHT, -1, 1'b0, -1);
    idle(3);
    check("ss_busy_after", 32'(vif1.busy), 32'd0);
    check("ss_frame_cnt", 32'(vif1.frame_cnt), 32'd1);

    // display lock on buffer 1 after buffer 0 completed; lock changes mid-frame are ignored
    vif1.disp_lock = 1'b1;
    vif1.disp_buf  = 2'd1;
    exp_q.push_back(rec(32'h1200, 2'd2, 16'd2, 8'd32, 4'd0, 4'd0));
    pulse_req();
    check("lock_frame_base", vif1.frame_base, 32'h1200);
    check("lock2_frame_base", vif2.frame_base, 32'h1000);
    vif1.disp_buf = 2'd2;
    send_lines(HEIGHT, -1, 1'b0, -1);
    idle(3);
    vif1.disp_lock = 1'b0;
    vif1.disp_buf  = 2'd0;

    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    check("rst2_frame_cnt", 32'(vif1.frame_cnt), 32'd0);

    // continuous capture of four frames, dropped during the last one
    exp_q.push_back(rec(32'h1000, 2'd0, 16'd1, 8'd32, 4'd0, 4'd0));
    exp_q.push_back(rec(32'h1100, 2'd1, 16'd2, 8'd32, 4'd0, 4'd0));
    exp_q.push_back(rec(32'h1200, 2'd2, 16'd3, 8'd32, 4'd0, 4'd0));
    exp_q.push_back(rec(32'h1000, 2'd0, 16'd4, 8'd32, 4'd0, 4'd0));
    vif1.cap_cont = 1'b1;
    step();
    for (int f = 0; f < 4; f++) begin
      if (f == 3) vif1.cap_cont = 1'b0;
      send_lines(HEIGHT, -1, 1'b0, -1);
      idle(2);
    end
    idle(2);
    check("cont_busy_after", 32'(vif1.busy), 32'd0);
    check("cont_frame_cnt", 32'(vif1.frame_cnt), 32'd4);

    // short line 1: one err_line, frame still completes
    exp_q.push_back(rec(32'h1100, 2'd1, 16'd5, 8'd31, 4'd1, 4'd0));
    pulse_req();
    idle(1);
    send_lines(HEIGHT, 1, 1'b0, -1);
    idle(3);

    // premature SOF after two lines: err_frame, restart in same buffer
    exp_q.push_back(rec(32'h1200, 2'd2, 16'd6, 8'd48, 4'd0, 4'd1));
    pulse_req();
    idle(1);
    send_lines(2, -1, 1'b0, -1);
    check("psof_cap_en", 32'(vif1.cap_en), 32'd1);
    send_lines(HEIGHT, -1, 1'b0, -1);
    idle(3);

    // 50% tvalid with junk framing on idle cycles
    exp_q.push_back(rec(32'h1000, 2'd0, 16'd7, 8'd32, 4'd0, 4'd0));
    pulse_req();
    idle(1);
    send_lines(HEIGHT, -1, 1'b1, -1);
    idle(3);

    // late request mid-frame, then a second request while busy
    exp_q.push_back(rec(32'h1100, 2'd1, 16'd8, 8'd32, 4'd0, 4'd0));
    send_lines(HEIGHT, -1, 1'b0, 10);
    check("late_busy_armed", 32'(vif1.busy), 32'd1);
    check("late_frame_base", vif1.frame_base, 32'h1100);
    idle(2);
    send_lines(HEIGHT, -1, 1'b0, 5);
    idle(3);
    check("late_busy_after", 32'(vif1.busy), 32'd0);
    check("late_frame_cnt", 32'(vif1.frame_cnt), 32'd8);

    // reset mid-capture aborts with no frame_done
    pulse_req();
    idle(1);
    send_lines(2, -1, 1'b0, -1);
    check("abort_cap_en_before", 32'(vif1.cap_en), 32'd1);
    rst = 1'b1;
    idle(1);
    check("abort_cap_en", 32'(vif1.cap_en), 32'd0);
    check("abort_busy", 32'(vif1.busy), 32'd0);
    check("abort_frame_done", 32'(vif1.frame_done), 32'd0);
    rst = 1'b0;
    exp_q.push_back(rec(32'h1000, 2'd0, 16'd1, 8'd32, 4'd0, 4'd0));
    pulse_req();
    check("abort_next_base", vif1.frame_base, 32'h1000);
    idle(1);
    send_lines(HEIGHT, -1, 1'b0, -1);
    idle(4);

    check("exp_q_drained", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
